cix_rr_arbiter: RTL
===================

Name: cix_rr_arbiter

Overview:
Round-robin arbiter and sequencer that shares the single custom-instruction unit (FFT / ENC / DEC, 19-bit) among NUM_REQ requesters. It accepts one request at a time, decodes and validates the opcode, and dispatches it to the unit with a start pulse. It then waits for the unit's done, and returns the result to the originating requester over a valid/ready response handshake. It sits between the CPU issue ports (or coprocessor clients) and the shared custom unit.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 19, operand/result width
OP_W, 5, opcode width
TIMEOUT_CYC, 64, watchdog limit in WAIT cycles (used only with CIX_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
req_op  in  NUM_REQ*OP_W  packed opcodes, requester i at [i*OP_W +: OP_W]
req_data  in  NUM_REQ*DATA_W  packed operands
rsp_valid  out  NUM_REQ  response valid, one-hot to originating requester
rsp_ready  in  NUM_REQ  response accept
rsp_data  out  DATA_W  response result (shared bus)
rsp_err  out  1  response error flag (illegal opcode / timeout)
cu_start  out  1  one-cycle dispatch pulse to custom unit
cu_op  out  OP_W  opcode to unit, registered
cu_data  out  DATA_W  operand to unit, registered
cu_done  in  1  unit completion pulse
cu_result  in  DATA_W  unit result, valid with cu_done
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async): state IDLE, all outputs 0, rr pointer = NUM_REQ-1 (requester 0 wins first arbitration), captured op/data/id/result = 0.
- States: IDLE, START, WAIT, RESP.
- IDLE: if any req_valid, grant = first asserted index searching from pointer+1 with wrap. req_ready[grant] is combinational, high this cycle only. Capture op, data and id, and set pointer = grant. Legal op (10000, 10001, 10010) -> START. Illegal op -> RESP with rsp_data=0, rsp_err=1, no cu_start.
- START: cu_start=1 for exactly one cycle; cu_op/cu_data hold captured values through START and WAIT. -> WAIT.
- WAIT: cu_done sampled only here. On cu_done, capture cu_result, rsp_err=0 -> RESP. cu_done in IDLE/START/RESP is ignored.
- RESP: rsp_valid[id]=1, rsp_data/rsp_err stable until rsp_ready[id]; on handshake -> IDLE. No new grant while not IDLE, and req_ready stays 0.
- Latency: handshake in cycle 0, cu_start in cycle 1. For a unit with cu_done L cycles after cu_start (L>=1), rsp_valid is first high in cycle 2+L. An illegal op gives rsp_valid in cycle 1.
- Requesters hold req_valid/op/data stable until req_ready; rsp_ready of non-addressed requesters is ignored.
- Reset mid-operation aborts silently: no response is generated and the pointer returns to NUM_REQ-1.
- Throughput: one operation per 3+L cycles minimum when rsp_ready is held high.

Optional Feature:
CIX_TIMEOUT_EN: defined -> a counter runs in WAIT. If cu_done is not seen within TIMEOUT_CYC cycles, go to RESP with rsp_data=0, rsp_err=1, and ignore any late cu_done. The counter clears on entry to WAIT. Undefined -> WAIT holds indefinitely, no counter logic.

Decomposition:
Package cix_pkg: OP_FFT=5'b10000, OP_ENC=5'b10001, OP_DEC=5'b10010, DATA_W=19, OP_W=5, state enum type, is_legal_op function. Sub-module cix_rr_pick: combinational round-robin picker (req vector + pointer -> one-hot grant + index), reusable by other shared-resource arbiters.

Test Plan:
Single op: req0 FFT data 19'h00002, bench unit L=2 returns data+1 -> cu_start cycle 1 with cu_op 10000/cu_data 00002, rsp_valid[0] cycle 4, rsp_data 19'h00003, rsp_err 0.
Fairness: req0..3 all valid continuously with ENC ops, rsp_ready=1 -> grant order 0,1,2,3,0,1; each rsp_data = data ^ 19'h2AAAA to the correct requester.
Illegal op: req2 opcode 00000 -> rsp_valid[2] cycle 1, rsp_data 0, rsp_err 1, cu_start never asserted.
Backpressure: rsp_ready[1] low 5 cycles during RESP while req3 valid -> rsp_valid/rsp_data stable, req_ready all 0, req3 granted the cycle after handshake.
Reset in WAIT: rst pulse, then stray cu_done -> all outputs 0, no rsp_valid; next simultaneous req0/req1 grants req0.
Timeout (CIX_TIMEOUT_EN, TIMEOUT_CYC=8): unit never done -> rsp_err 1, rsp_data 0 after 8 WAIT cycles; a later cu_done is ignored.

Source files
------------

// File: rtl/cix_pkg.sv
// Shared opcodes, widths and FSM state type for the custom-instruction arbiter.
package cix_pkg;

  localparam int DATA_W = 19;
  localparam int OP_W   = 5;

  localparam logic [OP_W-1:0] OP_FFT = 5'b10000;
  localparam logic [OP_W-1:0] OP_ENC = 5'b10001;
  localparam logic [OP_W-1:0] OP_DEC = 5'b10010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } cix_state_e;

  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    return (op == OP_FFT) || (op == OP_ENC) || (op == OP_DEC);
  endfunction

endpackage

// File: rtl/cix_rr_pick.sv
// Combinational round-robin picker: first asserted request searching upward from ptr+1 with wrap.
// Zero latency; no flow control of its own, the caller decides when a grant is taken.
module cix_rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [IDX_W-1:0] cand;

  // k runs 1..NUM_REQ so the last-granted requester is checked last.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (!any && req[cand]) begin
        any         = 1'b1;
        idx         = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cix_rr_arbiter.sv
// Round-robin sequencer sharing one custom unit: grant in cycle 0, cu_start in 1, response at 2+L.
// One op in flight; holds the response until the addressed rsp_ready. Watchdog under CIX_TIMEOUT_EN.
module cix_rr_arbiter
  import cix_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = cix_pkg::DATA_W,
  parameter int OP_W    = cix_pkg::OP_W
`ifdef CIX_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 64
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*OP_W-1:0]   req_op,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_err,
  output logic                      cu_start,
  output logic [OP_W-1:0]           cu_op,
  output logic [DATA_W-1:0]         cu_data,
  input  logic                      cu_done,
  input  logic [DATA_W-1:0]         cu_result,
  output logic                      busy
);

  localparam int IDX_W = $clog2(NUM_REQ);

  cix_state_e          state;
  logic [IDX_W-1:0]    ptr;
  logic [NUM_REQ-1:0]  id_oh;
  logic [OP_W-1:0]     op_q;
  logic [DATA_W-1:0]   data_q;

  logic [NUM_REQ-1:0]  gnt_oh;
  logic [IDX_W-1:0]    gnt_idx;
  logic                gnt_any;
  logic [OP_W-1:0]     op_sel;
  logic [DATA_W-1:0]   data_sel;
  logic                rsp_hs;

`ifdef CIX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt;
`endif

  cix_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (gnt_oh),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  always_comb begin
    op_sel   = '0;
    data_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_oh[i]) begin
        op_sel   = req_op[i*OP_W +: OP_W];
        data_sel = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Grants are only offered in IDLE, so at most one requester sees ready.
  assign req_ready = (state == ST_IDLE) ? gnt_oh : '0;
  assign rsp_hs    = (state == ST_RESP) && ((rsp_ready & id_oh) != '0);
  assign busy      = (state != ST_IDLE);
  assign cu_op     = op_q;
  assign cu_data   = data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      ptr       <= IDX_W'(NUM_REQ - 1);
      id_oh     <= '0;
      op_q      <= '0;
      data_q    <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      cu_start  <= 1'b0;
`ifdef CIX_TIMEOUT_EN
      to_cnt    <= '0;
`endif
    end else begin
      cu_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (gnt_any) begin
            ptr    <= gnt_idx;
            id_oh  <= gnt_oh;
            op_q   <= op_sel;
            data_q <= data_sel;
            if (is_legal_op(op_sel)) begin
              state    <= ST_START;
              cu_start <= 1'b1;
            end else begin
              // Illegal opcodes never reach the unit; answer directly with an error.
              state     <= ST_RESP;
              rsp_valid <= gnt_oh;
              rsp_data  <= '0;
              rsp_err   <= 1'b1;
            end
          end
        end
        ST_START: begin
          state <= ST_WAIT;
`ifdef CIX_TIMEOUT_EN
          to_cnt <= '0;
`endif
        end
        ST_WAIT: begin
          if (cu_done) begin
            state     <= ST_RESP;
            rsp_valid <= id_oh;
            rsp_data  <= cu_result;
            rsp_err   <= 1'b0;
          end
`ifdef CIX_TIMEOUT_EN
          else if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
            state     <= ST_RESP;
            rsp_valid <= id_oh;
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        ST_RESP: begin
          if (rsp_hs) begin
            state     <= ST_IDLE;
            rsp_valid <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
